// File: rtl/stage_if.sv
// Instruction-fetch stage: PC, req/ack fetch FSM, IF/ID register and a
// one-entry skid buffer so no fetched word is lost while ID stalls.
module stage_if #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] pc_id,
    output logic [31:0] pc_plus4_id,
    output logic        instr_valid
);

    typedef enum logic [1:0] {READY, BUSY, DISCARD} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_data_q, skid_data_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic [31:0] pc_plus4_id_q, pc_plus4_id_d;
    logic        instr_valid_q, instr_valid_d;

    logic [31:0] target;
    logic        accept;

    assign target    = redirect_pc & ~32'h3;
    assign imem_addr = pc_q;
    assign imem_req  = (state_q == BUSY) || (state_q == DISCARD) ||
                       ((state_q == READY) && !skid_valid_q && !redirect);
    // A word acked while draining a redirected request is never accepted.
    assign accept    = imem_req && imem_ack && !redirect &&
                       (state_q != DISCARD);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_pc_d     = pend_pc_q;
        skid_valid_d  = skid_valid_q;
        skid_data_d   = skid_data_q;
        skid_pc_d     = skid_pc_q;
        instr_d       = instr_q;
        pc_id_d       = pc_id_q;
        pc_plus4_id_d = pc_plus4_id_q;
        instr_valid_d = instr_valid_q;

        unique case (state_q)
            READY: begin
                if (redirect) begin
                    pc_d = target;
                end else if (imem_req && !imem_ack) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (imem_ack) begin
                    state_d = READY;
                    if (redirect) pc_d = target;
                end else if (redirect) begin
                    state_d   = DISCARD;
                    pend_pc_d = target;
                end
            end
            DISCARD: begin
                if (imem_ack) begin
                    state_d = READY;
                    pc_d    = redirect ? target : pend_pc_q;
                end else if (redirect) begin
                    pend_pc_d = target;
                end
            end
            default: state_d = READY;
        endcase

        if (accept) pc_d = pc_q + 32'd4;

        if (redirect) begin
            instr_valid_d = 1'b0;
            instr_d       = NOP_INSTR;
            skid_valid_d  = 1'b0;
        end else if (accept) begin
            if (!stall || !instr_valid_q) begin
                instr_d       = imem_rdata;
                pc_id_d       = pc_q;
                pc_plus4_id_d = pc_q + 32'd4;
                instr_valid_d = 1'b1;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = imem_rdata;
                skid_pc_d    = pc_q;
            end
        end else if (!stall) begin
            if (skid_valid_q) begin
                instr_d       = skid_data_q;
                pc_id_d       = skid_pc_q;
                pc_plus4_id_d = skid_pc_q + 32'd4;
                instr_valid_d = 1'b1;
                skid_valid_d  = 1'b0;
            end else begin
                instr_valid_d = 1'b0;
                instr_d       = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= READY;
            pc_q          <= RESET_PC;
            pend_pc_q     <= RESET_PC;
            skid_valid_q  <= 1'b0;
            skid_data_q   <= NOP_INSTR;
            skid_pc_q     <= 32'h0;
            instr_q       <= NOP_INSTR;
            pc_id_q       <= 32'h0;
            pc_plus4_id_q <= 32'h0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_pc_q     <= pend_pc_d;
            skid_valid_q  <= skid_valid_d;
            skid_data_q   <= skid_data_d;
            skid_pc_q     <= skid_pc_d;
            instr_q       <= instr_d;
            pc_id_q       <= pc_id_d;
            pc_plus4_id_q <= pc_plus4_id_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign instr       = instr_q;
    assign pc_id       = pc_id_q;
    assign pc_plus4_id = pc_plus4_id_q;
    assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: cycle table for streaming/stall, scoreboard of
// consumed instructions, and hand-written redirect/reset sequences.
module tb_stage_if;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] BASE = 32'h0010_0093;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] pc_id;
    logic [31:0] pc_plus4_id;
    logic        instr_valid;

    int checks   = 0;
    int failures = 0;
    int mem_lat  = 0;
    int wait_cnt;
    logic [31:0] exp_q[$];

    stage_if dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr      (instr),
        .pc_id      (pc_id),
        .pc_plus4_id(pc_plus4_id),
        .instr_valid(instr_valid)
    );

    always #5 clk = ~clk;

    // Memory: acks once a request has waited mem_lat cycles (0 = same cycle).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_cnt <= 0;
        else if (imem_req && imem_ack) wait_cnt <= 0;
        else if (imem_req) wait_cnt <= wait_cnt + 1;
    end
    assign imem_ack   = imem_req && (wait_cnt >= mem_lat);
    assign imem_rdata = BASE + imem_addr;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ID consumes the IF/ID word whenever it is valid and not stalled.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && instr_valid === 1'b1 && stall === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_extra actual pc_id=%h expected none",
                         pc_id);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("sb_pc", pc_id, e);
                chk("sb_pc4", pc_plus4_id, e + 32'd4);
                chk("sb_instr", instr, BASE + e);
            end
        end
    end

    task automatic reset_dut();
        #1;
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic cyc(input logic s, input logic r, input logic [31:0] rp);
        @(posedge clk);
        #1;
        stall       = s;
        redirect    = r;
        redirect_pc = rp;
        @(negedge clk);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cyc(1'b0, 1'b0, 32'h0);
            #1;
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'h0);
        exp_q.delete();
    endtask

    typedef struct {
        logic        st;
        logic        rd;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pcid;
        logic [31:0] pc4;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic req,
                                input logic [31:0] addr, input logic vld,
                                input logic [31:0] pcid,
                                input logic [31:0] pc4);
        vec_t v;
        v.st   = st;
        v.rd   = 1'b0;
        v.rpc  = 32'h0;
        v.req  = req;
        v.addr = addr;
        v.vld  = vld;
        v.pcid = pcid;
        v.pc4  = pc4;
        return v;
    endfunction

    vec_t tbl[8];

    initial begin
        tbl[0] = mk(1'b0, 1'b1, 32'd0,  1'b0, 32'd0,  32'd0);
        tbl[1] = mk(1'b0, 1'b1, 32'd4,  1'b1, 32'd0,  32'd4);
        tbl[2] = mk(1'b1, 1'b1, 32'd8,  1'b1, 32'd4,  32'd8);
        tbl[3] = mk(1'b1, 1'b0, 32'd12, 1'b1, 32'd4,  32'd8);
        tbl[4] = mk(1'b1, 1'b0, 32'd12, 1'b1, 32'd4,  32'd8);
        tbl[5] = mk(1'b0, 1'b0, 32'd12, 1'b1, 32'd4,  32'd8);
        tbl[6] = mk(1'b0, 1'b1, 32'd12, 1'b1, 32'd8,  32'd12);
        tbl[7] = mk(1'b0, 1'b1, 32'd16, 1'b1, 32'd12, 32'd16);

        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        // Streaming with zero-wait memory, then a 3-cycle stall.
        mem_lat = 0;
        reset_dut();
        exp_q = '{32'd0, 32'd4, 32'd8, 32'd12};
        for (int i = 0; i < 8; i++) begin
            if (i > 0) cyc(tbl[i].st, tbl[i].rd, tbl[i].rpc);
            chk($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].req));
            chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_vld", i), 32'(instr_valid),
                32'(tbl[i].vld));
            chk($sformatf("tbl%0d_pcid", i), pc_id, tbl[i].pcid);
            chk($sformatf("tbl%0d_pc4", i), pc_plus4_id, tbl[i].pc4);
            chk($sformatf("tbl%0d_instr", i), instr,
                tbl[i].vld ? BASE + tbl[i].pcid : NOP);
        end
        #1;
        chk("tbl_sb_empty", 32'(exp_q.size()), 32'h0);
        exp_q.delete();

        // Redirect while waiting on a 3-cycle memory.
        mem_lat = 3;
        reset_dut();
        exp_q = '{32'h100, 32'h104};
        chk("t3_c0_addr", imem_addr, 32'h0);
        cyc(1'b0, 1'b1, 32'h100);
        chk("t3_c1_addr", imem_addr, 32'h0);
        chk("t3_c1_req", 32'(imem_req), 32'h1);
        cyc(1'b0, 1'b0, 32'h0);
        chk("t3_hold_addr", imem_addr, 32'h0);
        chk("t3_nop", instr, NOP);
        cyc(1'b0, 1'b0, 32'h0);
        chk("t3_ack", 32'(imem_ack), 32'h1);
        chk("t3_ack_addr", imem_addr, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("t3_new_addr", imem_addr, 32'h100);
        chk("t3_vld", 32'(instr_valid), 32'h0);
        chk("t3_instr_nop", instr, NOP);
        drain("t3_drain", 40);

        // Redirect and ack in the same cycle under stall.
        mem_lat = 2;
        reset_dut();
        exp_q = '{32'h40, 32'h44};
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        chk("t4_vld", 32'(instr_valid), 32'h1);
        chk("t4_pcid", pc_id, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 32'h40);
        chk("t4_ack", 32'(imem_ack && imem_req), 32'h1);
        cyc(1'b0, 1'b0, 32'h0);
        chk("t4_flush_vld", 32'(instr_valid), 32'h0);
        chk("t4_flush_nop", instr, NOP);
        chk("t4_restart_addr", imem_addr, 32'h40);
        chk("t4_restart_req", 32'(imem_req), 32'h1);
        drain("t4_drain", 40);

        // Two redirects while discarding; low address bits ignored.
        mem_lat = 4;
        reset_dut();
        exp_q = '{32'h300, 32'h304};
        cyc(1'b0, 1'b1, 32'h200);
        cyc(1'b0, 1'b1, 32'h303);
        chk("t5_c2_addr", imem_addr, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("t5_c3_addr", imem_addr, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("t5_ack", 32'(imem_ack), 32'h1);
        chk("t5_ack_addr", imem_addr, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("t5_new_addr", imem_addr, 32'h300);
        drain("t5_drain", 60);

        // Wrap of pc and pc+4, then async reset mid-request.
        mem_lat = 0;
        reset_dut();
        exp_q = '{32'h0, 32'hFFFF_FFFC, 32'h0};
        cyc(1'b0, 1'b1, 32'hFFFF_FFFC);
        chk("t6_redir_req", 32'(imem_req), 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("t6_wrap_addr", imem_addr, 32'hFFFF_FFFC);
        chk("t6_wrap_vld", 32'(instr_valid), 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("t6_addr0", imem_addr, 32'h0);
        chk("t6_pcid", pc_id, 32'hFFFF_FFFC);
        chk("t6_pc4_wrap", pc_plus4_id, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        #1;
        chk("t6_sb_empty", 32'(exp_q.size()), 32'h0);
        @(posedge clk);
        #1;
        mem_lat = 3;
        stall   = 1'b1;
        @(negedge clk);
        chk("t6_pre_vld", 32'(instr_valid), 32'h1);
        chk("t6_pre_pcid", pc_id, 32'h4);
        cyc(1'b1, 1'b0, 32'h0);
        chk("t6_busy_addr", imem_addr, 32'h8);
        chk("t6_busy_req", 32'(imem_req), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_vld", 32'(instr_valid), 32'h0);
        chk("t6_rst_instr", instr, NOP);
        chk("t6_rst_pcid", pc_id, 32'h0);
        chk("t6_rst_pc4", pc_plus4_id, 32'h0);
        chk("t6_rst_addr", imem_addr, 32'h0);
        stall = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t6_rel_addr", imem_addr, 32'h0);
        chk("t6_rel_req", 32'(imem_req), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stage_if.md
Name: stage_if

Overview:
Instruction-fetch stage that sits directly upstream of stage_ID and drives its instr input.
- Holds the program counter and fetches from an instruction memory over a req/ack handshake; memory latency is variable.
- Presents each fetched instruction, its PC and PC+4 in an IF/ID register.
- Honours stall from ID and redirect (branch/jump/flush) from EX, with a one-entry skid buffer so no fetched word is lost.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset.
NOP_INSTR, 32'h0000_0013, value of instr when the stage holds no valid instruction (addi x0,x0,0).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request; held high with stable imem_addr until imem_ack
imem_addr  out  32  fetch address (current PC)
imem_ack  in  1  request complete; imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction word
stall  in  1  ID cannot accept; IF/ID register must hold
redirect  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  32  new fetch address (bits [1:0] ignored, forced 0)
instr  out  32  IF/ID instruction to stage_ID
pc_id  out  32  PC of instr
pc_plus4_id  out  32  pc_id + 4, modulo 2^32
instr_valid  out  1  instr is a real instruction

Behaviour:
Reset (async, any time, including mid-request):
- pc = RESET_PC; instr = NOP_INSTR; pc_id = 0; pc_plus4_id = 0; instr_valid = 0.
- skid empty; FSM = READY. An outstanding request is abandoned; the memory is reset by the same rst_n.

State:
- pc register; FSM {READY, BUSY, DISCARD}; skid register {valid, data, pc}.
- imem_addr = pc.
- imem_req = (state==BUSY) | (state==DISCARD) | (state==READY & !skid_valid & !redirect).
- A request is done in any cycle where imem_req & imem_ack; zero-wait ack in the issue cycle is legal.

FSM transitions:
- READY, issuing, ack: stay READY and accept the word. No ack: go to BUSY.
- READY, not issuing: stay READY.
- BUSY, ack, no redirect: go to READY and accept the word.
- BUSY, ack with redirect: go to READY and drop the word.
- BUSY, redirect without ack: go to DISCARD.
- DISCARD: hold req/addr at the old address. On ack, drop the word and go to READY.

Accepting a word (pc = P, data = D):
- pc <= P+4 (wraps at 2^32).
- If !stall | !instr_valid: IF/ID <= {D, P, P+4, valid=1}.
- Otherwise: skid <= {D, P}.
- Invariant: skid full and ack never coincide, because no request issues while skid is valid.

IF/ID update when nothing is accepted:
- If !stall & skid_valid: IF/ID <= skid; skid cleared.
- Else if !stall: instr_valid <= 0, instr <= NOP_INSTR, pc_id and pc_plus4_id hold.
- If stall & instr_valid: all IF/ID outputs hold.

Redirect (highest priority, overrides stall):
- instr_valid <= 0; instr <= NOP_INSTR; skid cleared; pc <= {redirect_pc[31:2], 2'b00}.
- In DISCARD the address output still holds the old address until ack. The new pc lives in a pending register.
- A second redirect in DISCARD overwrites the pending pc; the last one wins.
- Redirect and ack in the same cycle in BUSY or DISCARD: drop the word, go to READY, pc = new redirect target.

Latency:
- With zero-wait memory and no stall: one instruction per cycle.
- instr is visible the cycle after ack.

Test Plan:
1. Reset release, zero-wait memory returning word = 32'h00100093 + addr: imem_addr 0,4,8 on consecutive cycles; instr_valid=1 from cycle 2; pc_id 0,4,8; pc_plus4_id 4,8,12.
2. Stall for 3 cycles while an ack arrives: IF/ID holds pc_id=4. Word for pc 8 goes to skid; imem_req=0 while skid full. After stall drops: pc_id=8, then fetch resumes at 12. No word lost or duplicated.
3. Memory latency 3 cycles, redirect to 32'h0000_0100 on cycle 1 of wait: imem_addr stays old until ack. That word is dropped, next imem_addr=0x100, first valid pc_id=0x100. instr_valid=0 with instr=32'h00000013 in between.
4. Redirect and ack in the same cycle while stall=1: acked word is dropped, instr_valid=0 next cycle, fetch restarts at the redirect target.
5. Two redirects (0x200 then 0x300) during DISCARD: only 0x300 is fetched. redirect_pc=0x303 fetches 0x300.
6. rst_n low mid-request with valid IF/ID: all outputs reset immediately, without a clock edge. After release, the first imem_addr is RESET_PC. Wrap case: redirect to 32'hFFFF_FFFC gives next imem_addr 0 and pc_plus4_id 0.
